// File: rtl/transceiver_pkg.sv
// Shared types and defaults for the transceiver sequencing logic.
// Holds the scheduler state encoding and the counter sizing helper.
package transceiver_pkg;

   localparam int BITS_PER_WORD_DFLT   = 12;
   localparam int DATA_WIDTH_DFLT      = 8;
   localparam int SAMPLES_PER_BIT_DFLT = 256;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      MODULATE = 3'd2,
      TX_START = 3'd3,
      TX_WAIT  = 3'd4
   } sched_state_e;

   // Bits needed to hold n-1; never less than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with a registered occupancy level.
// A push while full is accepted only when a pop happens in the same cycle.
module byte_fifo
   import transceiver_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       arst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [cnt_width(DEPTH):0]  level
);

   localparam int PW = cnt_width(DEPTH);
   localparam int LW = PW + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [LW-1:0]    level_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty     = (level_r == LW'(0));
   assign full      = (level_r == LW'(DEPTH));
   assign do_pop_s  = pop && !empty;
   assign do_push_s = push && (!full || do_pop_s);
   assign rd_data   = mem_r[rd_ptr_r];
   assign level     = level_r;

   // Pointer, level and storage update; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
            wr_ptr_r        <= wr_ptr_r + 1'b1;
         end
         if (do_pop_s) rd_ptr_r <= rd_ptr_r + 1'b1;
         case ({do_push_s, do_pop_s})
            2'b10:   level_r <= level_r + 1'b1;
            2'b01:   level_r <= level_r - 1'b1;
            default: level_r <= level_r;
         endcase
      end
   end

endmodule

// File: rtl/transceiver_scheduler.sv
// Sequences buffered UART bytes through encoder, one modulator burst and the
// UART transmitter, starting the next byte only after the transmitter is done.
module transceiver_scheduler
   import transceiver_pkg::*;
#(
   parameter int FIFO_DEPTH      = 4,
   parameter int ENC_LATENCY     = 1,
   parameter int BITS_PER_WORD   = BITS_PER_WORD_DFLT,
   parameter int SAMPLES_PER_BIT = SAMPLES_PER_BIT_DFLT,
   parameter int DATA_WIDTH      = DATA_WIDTH_DFLT
) (
   input  logic                            clk,
   input  logic                            arst,
   input  logic                            rx_dv,
   input  logic [DATA_WIDTH-1:0]           rx_data,
   output logic [DATA_WIDTH-1:0]           enc_data,
   output logic                            mod_en,
   output logic                            mod_start,
   output logic                            tx_dv,
   input  logic                            tx_done,
   output logic                            busy,
   output logic [cnt_width(FIFO_DEPTH):0]  fifo_level,
   output logic                            overflow
);

   localparam int BURST_LEN = BITS_PER_WORD * SAMPLES_PER_BIT;
   localparam int CW        = cnt_width(BURST_LEN);
   localparam int LCW       = cnt_width(ENC_LATENCY);

   sched_state_e          state_r;
   sched_state_e          next_s;
   logic [CW-1:0]         burst_cnt_r;
   logic [LCW-1:0]        lat_cnt_r;
   logic [DATA_WIDTH-1:0] enc_data_r;
   logic                  mod_en_r;
   logic                  mod_start_r;
   logic                  tx_dv_r;
   logic                  busy_r;
   logic                  overflow_r;
   logic [DATA_WIDTH-1:0] fifo_rd_s;
   logic                  full_s;
   logic                  empty_s;
   logic                  pop_s;

   assign pop_s = (state_r == IDLE) && !empty_s;

   byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .arst    (arst),
      .push    (rx_dv),
      .pop     (pop_s),
      .wr_data (rx_data),
      .rd_data (fifo_rd_s),
      .full    (full_s),
      .empty   (empty_s),
      .level   (fifo_level)
   );

   // Next-state decode; tx_done only matters while waiting for the transmitter.
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE: begin
            if (!empty_s) next_s = LOAD;
            else          next_s = IDLE;
         end
         LOAD: begin
            if (lat_cnt_r == LCW'(0)) next_s = MODULATE;
            else                      next_s = LOAD;
         end
         MODULATE: begin
            if (burst_cnt_r == CW'(0)) next_s = TX_START;
            else                       next_s = MODULATE;
         end
         TX_START: next_s = TX_WAIT;
         TX_WAIT: begin
            if (tx_done) next_s = IDLE;
            else         next_s = TX_WAIT;
         end
         default: next_s = IDLE;
      endcase
   end

   // State, counters and outputs; outputs are decoded from next_s so they align with the state.
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_r     <= IDLE;
         burst_cnt_r <= '0;
         lat_cnt_r   <= '0;
         enc_data_r  <= '0;
         mod_en_r    <= 1'b0;
         mod_start_r <= 1'b0;
         tx_dv_r     <= 1'b0;
         busy_r      <= 1'b0;
         overflow_r  <= 1'b0;
      end else begin
         state_r <= next_s;
         if (pop_s) begin
            enc_data_r <= fifo_rd_s;
            lat_cnt_r  <= LCW'(ENC_LATENCY - 1);
         end else if (state_r == LOAD && lat_cnt_r != LCW'(0)) begin
            lat_cnt_r <= lat_cnt_r - 1'b1;
         end
         if (state_r == LOAD && next_s == MODULATE) begin
            burst_cnt_r <= CW'(BURST_LEN - 1);
         end else if (state_r == MODULATE && burst_cnt_r != CW'(0)) begin
            burst_cnt_r <= burst_cnt_r - 1'b1;
         end
         mod_en_r    <= (next_s == MODULATE);
         mod_start_r <= (next_s == MODULATE) && (state_r != MODULATE);
         tx_dv_r     <= (next_s == TX_START);
         busy_r      <= (next_s != IDLE);
         overflow_r  <= overflow_r | (rx_dv & full_s & ~pop_s);
      end
   end

   assign enc_data  = enc_data_r;
   assign mod_en    = mod_en_r;
   assign mod_start = mod_start_r;
   assign tx_dv     = tx_dv_r;
   assign busy      = busy_r;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_transceiver_scheduler.sv
// Directed bench for transceiver_scheduler: bytes expected on the encoder are
// queued when sent and compared when each modulator burst starts.
module tb_transceiver_scheduler;

   localparam int DW        = 8;
   localparam int BURST_LEN = 12 * 4;

   logic          clk;
   logic          arst;
   logic          rx_dv;
   logic [DW-1:0] rx_data;
   logic [DW-1:0] enc_data;
   logic          mod_en;
   logic          mod_start;
   logic          tx_dv;
   logic          tx_done;
   logic          busy;
   logic [2:0]    fifo_level;
   logic          overflow;

   int            errors;
   int            checks;
   int            en_cnt;
   int            tx_cnt;
   logic [DW-1:0] sb[$];

   transceiver_scheduler #(
      .FIFO_DEPTH      (4),
      .ENC_LATENCY     (1),
      .BITS_PER_WORD   (12),
      .SAMPLES_PER_BIT (4),
      .DATA_WIDTH      (DW)
   ) dut (
      .clk        (clk),
      .arst       (arst),
      .rx_dv      (rx_dv),
      .rx_data    (rx_data),
      .enc_data   (enc_data),
      .mod_en     (mod_en),
      .mod_start  (mod_start),
      .tx_dv      (tx_dv),
      .tx_done    (tx_done),
      .busy       (busy),
      .fifo_level (fifo_level),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [DW-1:0] b, input bit expect_out);
      rx_dv   = 1'b1;
      rx_data = b;
      if (expect_out) sb.push_back(b);
      @(negedge clk);
      rx_dv = 1'b0;
   endtask

   task automatic wait_mod_en();
      for (int i = 0; i < 200 && !mod_en; i++) @(negedge clk);
      check("mod_en_timeout", 32'(mod_en), 32'd1);
   endtask

   task automatic wait_tx_dv();
      for (int i = 0; i < 300 && !tx_dv; i++) @(negedge clk);
      check("tx_dv_timeout", 32'(tx_dv), 32'd1);
   endtask

   // Complete the current byte: wait for the transmit start, then answer with tx_done.
   task automatic finish_tx(input int delay);
      wait_tx_dv();
      tick(delay);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   // Burst monitor: byte order at each burst start and burst length at each transmit start.
   always @(negedge clk) begin
      if (!arst) begin
         en_cnt <= 0;
      end else begin
         if (mod_start) begin
            check("start_first_cycle", 32'(en_cnt), 32'd0);
            check("start_with_mod_en", 32'(mod_en), 32'd1);
            if (sb.size() == 0) check("unexpected_burst", 32'(enc_data), 32'hFFFF_FFFF);
            else                check("burst_byte", 32'(enc_data), 32'(sb.pop_front()));
         end
         if (tx_dv) begin
            check("burst_len", 32'(en_cnt), 32'(BURST_LEN));
            check("mod_en_at_tx_dv", 32'(mod_en), 32'd0);
            tx_cnt <= tx_cnt + 1;
            en_cnt <= 0;
         end else if (mod_en) begin
            en_cnt <= en_cnt + 1;
         end
      end
   end

   initial begin
      int bad;
      errors  = 0;
      checks  = 0;
      en_cnt  = 0;
      tx_cnt  = 0;
      arst    = 1'b0;
      rx_dv   = 1'b0;
      rx_data = '0;
      tx_done = 1'b0;

      // Reset values
      #12;
      check("rst_enc_data", 32'(enc_data), 32'd0);
      check("rst_mod_en", 32'(mod_en), 32'd0);
      check("rst_mod_start", 32'(mod_start), 32'd0);
      check("rst_tx_dv", 32'(tx_dv), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      @(negedge clk);
      arst = 1'b1;
      tick(2);

      // Single byte 0xA5
      send(8'hA5, 1'b1);
      check("t1_level_after_push", 32'(fifo_level), 32'd1);
      check("t1_idle_before_pop", 32'(busy), 32'd0);
      @(negedge clk);
      check("t1_enc_data", 32'(enc_data), 32'hA5);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_level_after_pop", 32'(fifo_level), 32'd0);
      check("t1_load_no_mod_en", 32'(mod_en), 32'd0);
      @(negedge clk);
      check("t1_first_mod_en", 32'(mod_en), 32'd1);
      check("t1_mod_start", 32'(mod_start), 32'd1);
      finish_tx(20);
      check("t1_busy_done", 32'(busy), 32'd0);
      check("t1_tx_count", 32'(tx_cnt), 32'd1);
      tick(3);

      // Five back-to-back bytes while idle
      for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
      check("t2_level", 32'(fifo_level), 32'd4);
      check("t2_overflow", 32'(overflow), 32'd0);
      for (int i = 0; i < 5; i++) finish_tx(3);
      check("t2_busy_done", 32'(busy), 32'd0);
      check("t2_level_done", 32'(fifo_level), 32'd0);
      check("t2_tx_count", 32'(tx_cnt), 32'd6);
      tick(3);

      // Six bytes during a burst: two dropped
      send(8'h10, 1'b1);
      wait_mod_en();
      for (int i = 0; i < 6; i++) send(8'(8'h20 + i), (i < 4));
      check("t3_level_sat", 32'(fifo_level), 32'd4);
      check("t3_overflow", 32'(overflow), 32'd1);
      for (int i = 0; i < 5; i++) finish_tx(2);
      tick(10);
      check("t3_sb_empty", 32'(sb.size()), 32'd0);
      check("t3_busy_done", 32'(busy), 32'd0);

      // Transmitter never answers for 1000 cycles
      send(8'h30, 1'b1);
      send(8'h31, 1'b1);
      wait_tx_dv();
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (mod_en || tx_dv || !busy || fifo_level != 3'd1) bad++;
      end
      check("t4_stall_activity", 32'(bad), 32'd0);
      check("t4_enc_hold", 32'(enc_data), 32'h30);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      finish_tx(2);
      tick(3);
      check("t4_busy_done", 32'(busy), 32'd0);

      // Reset mid-burst with two bytes queued
      send(8'h40, 1'b1);
      wait_mod_en();
      send(8'h41, 1'b0);
      send(8'h42, 1'b0);
      tick(17);
      check("t5_in_burst", 32'(mod_en), 32'd1);
      arst = 1'b0;
      #1;
      check("t5_rst_mod_en", 32'(mod_en), 32'd0);
      check("t5_rst_level", 32'(fifo_level), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_overflow", 32'(overflow), 32'd0);
      @(negedge clk);
      arst = 1'b1;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (mod_en || tx_dv || busy || fifo_level != 3'd0) bad++;
      end
      check("t5_quiet_after_rst", 32'(bad), 32'd0);

      // Push while full coinciding with an idle pop
      send(8'h50, 1'b1);
      wait_mod_en();
      for (int i = 1; i <= 4; i++) send(8'(8'h50 + i), 1'b1);
      check("t6_full", 32'(fifo_level), 32'd4);
      finish_tx(3);
      send(8'h55, 1'b1);
      check("t6_level_kept", 32'(fifo_level), 32'd4);
      check("t6_no_overflow", 32'(overflow), 32'd0);
      check("t6_popped", 32'(enc_data), 32'h51);
      for (int i = 0; i < 5; i++) finish_tx(2);
      tick(5);
      check("t6_sb_empty", 32'(sb.size()), 32'd0);
      check("t6_level_done", 32'(fifo_level), 32'd0);
      check("t6_busy_done", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/transceiver_scheduler.md
# transceiver_scheduler

Sequencing controller for the transceiver datapath: it buffers bytes received by the UART receiver in a small FIFO and issues them one at a time to the Hamming encoder. For each byte it gates the BPSK modulator's enable for exactly one 12-bit codeword burst, then triggers the UART transmitter for the decoded loop-back byte. The next byte is started only after the transmitter reports done. It replaces the free-running `en` / `dv` wiring at the transceiver top level.

## Interface
- `FIFO_DEPTH`, 4: byte buffer entries; power of two, ≥2.
- `ENC_LATENCY`, 1: clocks from `enc_data` change to valid encoder output; ≥1.
- `BITS_PER_WORD`, 12: codeword bits modulated per byte.
- `SAMPLES_PER_BIT`, 256: modulator clocks per codeword bit.
- `DATA_WIDTH`, 8: byte width.

Ports:
- `clk` in 1: single system clock, rising edge.
- `arst` in 1: asynchronous, active-low reset.
- `rx_dv` in 1: one-cycle pulse, `rx_data` valid.
- `rx_data` in DATA_WIDTH: received byte.
- `enc_data` out DATA_WIDTH: byte presented to the encoder, held registered.
- `mod_en` out 1: modulator enable.
- `mod_start` out 1: one-cycle pulse on the first `mod_en` cycle of each burst.
- `tx_dv` out 1: one-cycle start pulse to the UART transmitter.
- `tx_done` in 1: transmitter completion pulse.
- `busy` out 1: state ≠ IDLE.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: occupied entries.
- `overflow` out 1: sticky, a byte was dropped.

## Operation
- FSM states: IDLE, LOAD, MODULATE, TX_START, TX_WAIT.
- IDLE:
  - If FIFO is non-empty: pop the head into `enc_data` and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - Remain for ENC_LATENCY cycles.
  - Then go to MODULATE.
- MODULATE:
  - `mod_en`=1 for exactly BITS_PER_WORD×SAMPLES_PER_BIT cycles, counted by an internal counter.
  - `mod_start`=1 on the first of those cycles.
  - After the last cycle, go to TX_START.
- TX_START: `tx_dv`=1 for one cycle, then go to TX_WAIT.
- TX_WAIT: wait for `tx_done`=1, then go to IDLE.
- `tx_done` is sampled only in TX_WAIT; it is ignored in every other state.
- FIFO push: `rx_dv`=1 and FIFO not full. Accepted in every FSM state.
- Push while full:
  - Without a same-cycle pop: byte dropped, `overflow` set, `fifo_level` unchanged.
  - With a same-cycle pop (IDLE→LOAD): byte accepted.
- Simultaneous push and pop: level unchanged; FIFO order preserved.
- Empty FIFO: no byte is popped; IDLE holds.
- Read and write pointers wrap modulo FIFO_DEPTH.
- `enc_data` keeps its last value outside LOAD/MODULATE; it changes only on a pop.
- `overflow` is cleared only by reset.

## Timing
- Reset values, applied asynchronously while `arst`=0:
  - `enc_data`=0, `mod_en`=0, `mod_start`=0, `tx_dv`=0, `busy`=0, `fifo_level`=0, `overflow`=0.
  - FIFO pointers 0; state IDLE.
- Reset asserted mid-burst: `mod_en` and `tx_dv` drop immediately and FIFO contents are discarded. The first pop after release takes at least one clock after `arst` rises.
- All outputs are registered; no combinational path from input to output.
- `rx_dv` at edge N: `fifo_level` increments at edge N+1.
- Pop latency: with the FIFO non-empty in IDLE at edge N, `enc_data` is updated and `busy`=1 at edge N+1.
- First `mod_en` cycle: ENC_LATENCY cycles after `enc_data` updates.
- `mod_en` deasserts on the cycle `tx_dv` asserts; there is no gap and no overlap.
- Minimum byte period: 1 + ENC_LATENCY + BITS_PER_WORD×SAMPLES_PER_BIT + 1 + (cycles until `tx_done`).
- A `tx_done` in the same cycle as entry to TX_WAIT is honoured: the FSM returns to IDLE on the next edge.
- Burst counter width: $clog2(BITS_PER_WORD×SAMPLES_PER_BIT). It counts down to 0 and never wraps within a burst.

## Structure
- Shared package `transceiver_pkg` holds:
  - FSM state encoding.
  - Default constants: BITS_PER_WORD=12, DATA_WIDTH=8, SAMPLES_PER_BIT=256.
  - Counter-width function.
- One sub-module: `byte_fifo`, a synchronous FIFO with registered level, parameterised on depth and width. It has push/pop/full/empty ports and the same `clk` / `arst`.
- FSM, burst counter and pulse generation stay in `transceiver_scheduler`.

## Test plan
- Bench parameters: SAMPLES_PER_BIT=4, ENC_LATENCY=1.
- Single byte 0xA5, `tx_done` 20 cycles after `tx_dv`:
  - `enc_data`=0xA5 one cycle after pop.
  - `mod_start` plus exactly 48 `mod_en` cycles.
  - One `tx_dv` pulse, then `busy`=0.
- Five back-to-back `rx_dv` (0x01–0x05), DEPTH=4, FSM idle:
  - First byte popped immediately, remaining four buffered.
  - `overflow` stays 0; bursts occur in order 01..05.
- Six `rx_dv` pulses while FSM is in MODULATE with an empty FIFO:
  - `fifo_level` saturates at 4 and `overflow`=1.
  - Fifth and sixth bytes never appear on `enc_data`.
- `tx_done` held low for 1000 cycles: FSM stays in TX_WAIT, `mod_en`=0, no further pops.
- `arst` low at burst cycle 20 with two bytes queued:
  - Immediately `mod_en`=0, `fifo_level`=0, `busy`=0.
  - After release, no activity until a new `rx_dv`.
- Push while full coinciding with an IDLE pop: byte accepted, `fifo_level` stays 4, `overflow`=0.
